// File: rtl/sys_pll_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sys_pll_ctrl_pkg
// Shared definitions for the system PLL sequencer: FSM state encodings, the
// state width, and a helper that sizes counters from their terminal count.
// -----------------------------------------------------------------------------
package sys_pll_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_EN_CLK    = 3'd2,
        ST_REL_RST   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } pll_state_e;

    // Width of a counter that runs 0 .. limit-1; never narrower than 1 bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/sys_pll_ctrl_if.sv
// -----------------------------------------------------------------------------
// sys_pll_ctrl_if
// Connection between the sequencer and the PLL macro.
//   pll_lock   PLL -> ctrl   raw LOCK output, asynchronous to clkin
//   pll_reset  ctrl -> PLL   PLL RESET
//   enclk      ctrl -> PLL   per-output clock enables ENCLK[NUM_CLK-1:0]
// master: sequencer side.  slave: PLL side.
// -----------------------------------------------------------------------------
interface sys_pll_ctrl_if #(
    parameter int NUM_CLK = 4
);
    logic               pll_lock;
    logic               pll_reset;
    logic [NUM_CLK-1:0] enclk;

    modport master (input pll_lock, output pll_reset, output enclk);
    modport slave  (output pll_lock, input pll_reset, input enclk);
endinterface

// File: rtl/sys_pll_ctrl_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level into the clkin domain.
//   clkin  in   destination clock
//   reset  in   synchronous, active-high; forces the output low
//   d      in   asynchronous input
//   q      out  synchronized level, two clkin cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clkin,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clkin) begin
        if (reset) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            // p0: capture (may go metastable); p1: resolved level
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;
endmodule

// File: rtl/sys_pll_ctrl.sv
// -----------------------------------------------------------------------------
// sys_pll_ctrl
// Power-up / recovery sequencer for the system PLL, clocked by the free-running
// PLL reference. Holds the PLL in reset, waits for a qualified lock (retrying
// on timeout), enables the gated outputs one at a time, then releases the
// per-domain resets. Lock loss tears everything down and restarts.
// Ports:
//   clkin      in   reference clock, the only clock in the block
//   reset      in   synchronous, active-high
//   restart    in   1-cycle pulse: restart from HOLD, clears lock_lost
//   pll        if   master side of sys_pll_ctrl_if (pll_lock, pll_reset, enclk)
//   dom_rst    out  per-domain reset request, active-high
//   ready      out  all masked domains running
//   fail       out  retries exhausted; sticky until restart/reset
//   lock_lost  out  sticky: lock dropped while in RUN
//   retry_cnt  out  failed lock attempts in the current sequence
//   state      out  current FSM state
// -----------------------------------------------------------------------------
module sys_pll_ctrl
    import sys_pll_ctrl_pkg::*;
#(
    parameter int                 NUM_CLK      = 4,
    parameter logic [NUM_CLK-1:0] CLK_EN_MASK  = {NUM_CLK{1'b1}},
    parameter int                 RST_CYCLES   = 64,
    parameter int                 LOCK_STABLE  = 256,
    parameter int                 LOCK_TIMEOUT = 50000,
    parameter int                 MAX_RETRY    = 3,
    parameter int                 ENCLK_GAP    = 16,
    parameter int                 RST_HOLD     = 32
) (
    input  logic                 clkin,
    input  logic                 reset,
    input  logic                 restart,
    sys_pll_ctrl_if.master       pll,
    output logic [NUM_CLK-1:0]   dom_rst,
    output logic                 ready,
    output logic                 fail,
    output logic                 lock_lost,
    output logic [1:0]           retry_cnt,
    output logic [STATE_W-1:0]   state
);

    // One phase counter serves HOLD, the enclk gap and the reset hold time,
    // since those phases never overlap.
    localparam int PH_LIM_A = (RST_CYCLES > ENCLK_GAP) ? RST_CYCLES : ENCLK_GAP;
    localparam int PH_LIM   = (PH_LIM_A > RST_HOLD) ? PH_LIM_A : RST_HOLD;
    localparam int PH_W     = cnt_width(PH_LIM);
    localparam int STB_W    = cnt_width(LOCK_STABLE);
    localparam int TMO_W    = cnt_width(LOCK_TIMEOUT);
    localparam int IDX_W    = $clog2(NUM_CLK + 1);

    localparam logic [PH_W-1:0]  PH_RST_LAST  = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_GAP_LAST  = PH_W'(ENCLK_GAP - 1);
    localparam logic [PH_W-1:0]  PH_HOLD_LAST = PH_W'(RST_HOLD - 1);
    localparam logic [STB_W-1:0] STB_LAST     = STB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);
    localparam bit               NO_CLK       = (CLK_EN_MASK == '0);

    // Lowest masked output index >= from, or NUM_CLK when none remain.
    function automatic int next_masked(input int from);
        int nb;
        nb = NUM_CLK;
        for (int i = NUM_CLK - 1; i >= 0; i--) begin
            if (i >= from && CLK_EN_MASK[i]) nb = i;
        end
        return nb;
    endfunction

    // One-hot of index n; all zeros for n outside the output range.
    function automatic logic [NUM_CLK-1:0] bit_of(input int n);
        logic [NUM_CLK-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CLK; i++) begin
            if (i == n) m[i] = 1'b1;
        end
        return m;
    endfunction

    pll_state_e         st_q;
    logic               pll_reset_q;
    logic [NUM_CLK-1:0] enclk_q;
    logic [NUM_CLK-1:0] dom_rst_q;
    logic               ready_q;
    logic               fail_q;
    logic               lock_lost_q;
    logic [1:0]         retry_q;
    logic [PH_W-1:0]    ph_q;
    logic [STB_W-1:0]   stb_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [IDX_W-1:0]   idx_q;      // next index to search from in EN_CLK
    logic               lock_s;
    logic               lock_drop;
    int                 nb_first;
    int                 nb_next;

    sync_2ff u_lock_sync (
        .clkin (clkin),
        .reset (reset),
        .d     (pll.pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        nb_first  = next_masked(0);
        nb_next   = next_masked(int'(idx_q));
        // Once clocks are being enabled, any lock drop restarts the sequence.
        lock_drop = !lock_s && (st_q inside {ST_EN_CLK, ST_REL_RST, ST_RUN});
    end

    always_ff @(posedge clkin) begin
        if (reset || restart) begin
            // restart is a full re-init, including the lock_lost flag
            st_q        <= ST_HOLD;
            pll_reset_q <= 1'b1;
            enclk_q     <= '0;
            dom_rst_q   <= '1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lock_lost_q <= 1'b0;
            retry_q     <= '0;
            ph_q        <= '0;
            stb_q       <= '0;
            tmo_q       <= '0;
            idx_q       <= '0;
        end else if (lock_drop) begin
            st_q        <= ST_HOLD;
            pll_reset_q <= 1'b1;
            enclk_q     <= '0;
            dom_rst_q   <= '1;
            ready_q     <= 1'b0;
            retry_q     <= '0;
            ph_q        <= '0;
            // only a drop from a fully running system is reported
            if (st_q == ST_RUN) lock_lost_q <= 1'b1;
        end else begin
            case (st_q)
                ST_HOLD: begin
                    if (ph_q == PH_RST_LAST) begin
                        st_q        <= ST_WAIT_LOCK;
                        pll_reset_q <= 1'b0;
                        ph_q        <= '0;
                        stb_q       <= '0;
                        tmo_q       <= '0;
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // lock qualification is checked first so it wins a tie
                    if (lock_s && stb_q == STB_LAST) begin
                        st_q    <= ST_EN_CLK;
                        enclk_q <= bit_of(nb_first);
                        idx_q   <= IDX_W'(nb_first + 1);
                        ph_q    <= '0;
                    end else if (tmo_q == TMO_LAST) begin
                        pll_reset_q <= 1'b1;
                        ph_q        <= '0;
                        if (retry_q == RETRY_MAX) begin
                            st_q   <= ST_FAIL;
                            fail_q <= 1'b1;
                        end else begin
                            st_q    <= ST_HOLD;
                            retry_q <= retry_q + 2'd1;
                        end
                    end else begin
                        stb_q <= lock_s ? stb_q + STB_W'(1) : '0;
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_EN_CLK: begin
                    if (NO_CLK) begin
                        st_q <= ST_REL_RST;
                        ph_q <= '0;
                    end else if (ph_q == PH_GAP_LAST) begin
                        ph_q <= '0;
                        if (nb_next < NUM_CLK) begin
                            enclk_q <= enclk_q | bit_of(nb_next);
                            idx_q   <= IDX_W'(nb_next + 1);
                        end else begin
                            st_q <= ST_REL_RST;
                        end
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                ST_REL_RST: begin
                    if (ph_q == PH_HOLD_LAST) begin
                        st_q      <= ST_RUN;
                        dom_rst_q <= ~CLK_EN_MASK;
                        ready_q   <= 1'b1;
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                ST_RUN: begin
                    // steady state; lock loss is handled above
                end
                ST_FAIL: begin
                    pll_reset_q <= 1'b1;
                    enclk_q     <= '0;
                    dom_rst_q   <= '1;
                    fail_q      <= 1'b1;
                end
                default: begin
                    st_q        <= ST_HOLD;
                    pll_reset_q <= 1'b1;
                    enclk_q     <= '0;
                    dom_rst_q   <= '1;
                    ready_q     <= 1'b0;
                    ph_q        <= '0;
                end
            endcase
        end
    end

    assign pll.pll_reset = pll_reset_q;
    assign pll.enclk     = enclk_q;
    assign dom_rst       = dom_rst_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign lock_lost     = lock_lost_q;
    assign retry_cnt     = retry_q;
    assign state         = st_q;

endmodule

// File: tb/tb_sys_pll_ctrl.sv
module tb_sys_pll_ctrl;
    import sys_pll_ctrl_pkg::*;

    logic clkin = 1'b0;
    logic reset;
    logic restart;
    logic lock_in;

    always #5 clkin = ~clkin;

    sys_pll_ctrl_if #(.NUM_CLK(4)) pif_a ();
    sys_pll_ctrl_if #(.NUM_CLK(4)) pif_b ();

    assign pif_a.pll_lock = lock_in;
    assign pif_b.pll_lock = lock_in;

    logic [3:0] dom_a, dom_b;
    logic       ready_a, ready_b, fail_a, fail_b, lost_a, lost_b;
    logic [1:0] retry_a, retry_b;
    logic [2:0] state_a, state_b;

    sys_pll_ctrl #(
        .NUM_CLK(4), .CLK_EN_MASK(4'hF), .RST_CYCLES(4), .LOCK_STABLE(8),
        .LOCK_TIMEOUT(100), .MAX_RETRY(2), .ENCLK_GAP(2), .RST_HOLD(3)
    ) dut_a (
        .clkin(clkin), .reset(reset), .restart(restart), .pll(pif_a),
        .dom_rst(dom_a), .ready(ready_a), .fail(fail_a), .lock_lost(lost_a),
        .retry_cnt(retry_a), .state(state_a)
    );

    sys_pll_ctrl #(
        .NUM_CLK(4), .CLK_EN_MASK(4'b0101), .RST_CYCLES(4), .LOCK_STABLE(8),
        .LOCK_TIMEOUT(100), .MAX_RETRY(2), .ENCLK_GAP(2), .RST_HOLD(3)
    ) dut_b (
        .clkin(clkin), .reset(reset), .restart(restart), .pll(pif_b),
        .dom_rst(dom_b), .ready(ready_b), .fail(fail_b), .lock_lost(lost_b),
        .retry_cnt(retry_b), .state(state_b)
    );

    typedef struct {
        int         k;
        logic       a_prst;
        logic [3:0] a_enclk;
        logic [3:0] a_dom;
        logic       a_ready;
        logic [2:0] a_state;
        logic [3:0] b_enclk;
        logic [3:0] b_dom;
        logic       b_ready;
        logic [2:0] b_state;
    } vec_t;

    vec_t vecs[14];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    task automatic tick();
        @(posedge clkin);
        @(negedge clkin);
    endtask

    task automatic adv_to(input int target);
        while (cyc < target) begin
            tick();
            cyc++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal bring-up; k = edges after the last reset edge.
        vecs[0]  = '{0,  1'b1, 4'h0, 4'hF, 1'b0, 3'd0, 4'h0, 4'hF, 1'b0, 3'd0};
        vecs[1]  = '{3,  1'b1, 4'h0, 4'hF, 1'b0, 3'd0, 4'h0, 4'hF, 1'b0, 3'd0};
        vecs[2]  = '{4,  1'b0, 4'h0, 4'hF, 1'b0, 3'd1, 4'h0, 4'hF, 1'b0, 3'd1};
        vecs[3]  = '{11, 1'b0, 4'h0, 4'hF, 1'b0, 3'd1, 4'h0, 4'hF, 1'b0, 3'd1};
        vecs[4]  = '{12, 1'b0, 4'h1, 4'hF, 1'b0, 3'd2, 4'h1, 4'hF, 1'b0, 3'd2};
        vecs[5]  = '{13, 1'b0, 4'h1, 4'hF, 1'b0, 3'd2, 4'h1, 4'hF, 1'b0, 3'd2};
        vecs[6]  = '{14, 1'b0, 4'h3, 4'hF, 1'b0, 3'd2, 4'h5, 4'hF, 1'b0, 3'd2};
        vecs[7]  = '{16, 1'b0, 4'h7, 4'hF, 1'b0, 3'd2, 4'h5, 4'hF, 1'b0, 3'd3};
        vecs[8]  = '{18, 1'b0, 4'hF, 4'hF, 1'b0, 3'd2, 4'h5, 4'hF, 1'b0, 3'd3};
        vecs[9]  = '{19, 1'b0, 4'hF, 4'hF, 1'b0, 3'd2, 4'h5, 4'hA, 1'b1, 3'd4};
        vecs[10] = '{20, 1'b0, 4'hF, 4'hF, 1'b0, 3'd3, 4'h5, 4'hA, 1'b1, 3'd4};
        vecs[11] = '{22, 1'b0, 4'hF, 4'hF, 1'b0, 3'd3, 4'h5, 4'hA, 1'b1, 3'd4};
        vecs[12] = '{23, 1'b0, 4'hF, 4'h0, 1'b1, 3'd4, 4'h5, 4'hA, 1'b1, 3'd4};
        vecs[13] = '{30, 1'b0, 4'hF, 4'h0, 1'b1, 3'd4, 4'h5, 4'hA, 1'b1, 3'd4};

        reset   = 1'b1;
        restart = 1'b0;
        lock_in = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        cyc   = 0;

        chk("rst_fail",  32'(fail_a), 32'h0);
        chk("rst_lost",  32'(lost_a), 32'h0);
        chk("rst_retry", 32'(retry_a), 32'h0);

        for (int i = 0; i < 14; i++) begin
            adv_to(vecs[i].k);
            chk("a_pll_reset", 32'(pif_a.pll_reset), 32'(vecs[i].a_prst));
            chk("a_enclk",     32'(pif_a.enclk),     32'(vecs[i].a_enclk));
            chk("a_dom_rst",   32'(dom_a),           32'(vecs[i].a_dom));
            chk("a_ready",     32'(ready_a),         32'(vecs[i].a_ready));
            chk("a_state",     32'(state_a),         32'(vecs[i].a_state));
            chk("b_enclk",     32'(pif_b.enclk),     32'(vecs[i].b_enclk));
            chk("b_dom_rst",   32'(dom_b),           32'(vecs[i].b_dom));
            chk("b_ready",     32'(ready_b),         32'(vecs[i].b_ready));
            chk("b_state",     32'(state_b),         32'(vecs[i].b_state));
        end

        // Lock loss in RUN: low for 3 samples, seen by the FSM 3 edges later.
        lock_in = 1'b0;
        cyc = 0;
        adv_to(2);
        chk("loss_still_run",  32'(state_a), 32'(ST_RUN));
        chk("loss_still_rdy",  32'(ready_a), 32'h1);
        adv_to(3);
        lock_in = 1'b1;
        chk("loss_ready",      32'(ready_a), 32'h0);
        chk("loss_enclk",      32'(pif_a.enclk), 32'h0);
        chk("loss_dom",        32'(dom_a), 32'hF);
        chk("loss_flag",       32'(lost_a), 32'h1);
        chk("loss_state",      32'(state_a), 32'(ST_HOLD));
        chk("loss_pll_reset",  32'(pif_a.pll_reset), 32'h1);
        chk("loss_retry",      32'(retry_a), 32'h0);
        adv_to(25);
        chk("reseq_relrst",    32'(state_a), 32'(ST_REL_RST));
        adv_to(26);
        chk("reseq_run",       32'(state_a), 32'(ST_RUN));
        chk("reseq_ready",     32'(ready_a), 32'h1);
        chk("reseq_lost_kept", 32'(lost_a), 32'h1);

        // restart in the same cycle the FSM sees the RUN lock drop.
        lock_in = 1'b0;
        cyc = 0;
        adv_to(2);
        chk("coll_pre_lost",  32'(lost_a), 32'h1);
        chk("coll_pre_state", 32'(state_a), 32'(ST_RUN));
        restart = 1'b1;
        adv_to(3);
        restart = 1'b0;
        chk("coll_state", 32'(state_a), 32'(ST_HOLD));
        chk("coll_lost",  32'(lost_a), 32'h0);
        chk("coll_ready", 32'(ready_a), 32'h0);
        chk("coll_enclk", 32'(pif_a.enclk), 32'h0);

        // Glitchy lock: 7 high, 1 low, then high.
        adv_to(7);
        chk("glitch_wait", 32'(state_a), 32'(ST_WAIT_LOCK));
        lock_in = 1'b1;
        cyc = 0;
        adv_to(7);
        lock_in = 1'b0;
        adv_to(8);
        lock_in = 1'b1;
        adv_to(17);
        chk("glitch_not_yet", 32'(state_a), 32'(ST_WAIT_LOCK));
        adv_to(18);
        chk("glitch_en_clk",  32'(state_a), 32'(ST_EN_CLK));
        chk("glitch_enclk",   32'(pif_a.enclk), 32'h1);

        // reset asserted mid-EN_CLK.
        adv_to(19);
        reset   = 1'b1;
        lock_in = 1'b0;
        adv_to(20);
        chk("midrst_pll_reset", 32'(pif_a.pll_reset), 32'h1);
        chk("midrst_enclk",     32'(pif_a.enclk), 32'h0);
        chk("midrst_dom",       32'(dom_a), 32'hF);
        chk("midrst_ready",     32'(ready_a), 32'h0);
        chk("midrst_state",     32'(state_a), 32'(ST_HOLD));
        adv_to(21);
        reset = 1'b0;

        // Timeout / retry with lock held low.
        cyc = 0;
        adv_to(103);
        chk("to1_wait",  32'(state_a), 32'(ST_WAIT_LOCK));
        chk("to1_retry", 32'(retry_a), 32'h0);
        adv_to(104);
        chk("to1_hold",  32'(state_a), 32'(ST_HOLD));
        chk("to1_cnt",   32'(retry_a), 32'h1);
        chk("to1_prst",  32'(pif_a.pll_reset), 32'h1);
        adv_to(207);
        chk("to2_wait",  32'(state_a), 32'(ST_WAIT_LOCK));
        adv_to(208);
        chk("to2_hold",  32'(state_a), 32'(ST_HOLD));
        chk("to2_cnt",   32'(retry_a), 32'h2);
        adv_to(311);
        chk("to3_wait",  32'(state_a), 32'(ST_WAIT_LOCK));
        chk("to3_nofail", 32'(fail_a), 32'h0);
        adv_to(312);
        chk("fail_state", 32'(state_a), 32'(ST_FAIL));
        chk("fail_flag",  32'(fail_a), 32'h1);
        chk("fail_prst",  32'(pif_a.pll_reset), 32'h1);
        chk("fail_retry", 32'(retry_a), 32'h2);
        chk("fail_dom",   32'(dom_a), 32'hF);
        adv_to(330);
        chk("fail_sticky", 32'(state_a), 32'(ST_FAIL));
        restart = 1'b1;
        adv_to(331);
        restart = 1'b0;
        chk("rs_fail",  32'(fail_a), 32'h0);
        chk("rs_retry", 32'(retry_a), 32'h0);
        chk("rs_state", 32'(state_a), 32'(ST_HOLD));
        chk("rs_prst",  32'(pif_a.pll_reset), 32'h1);
        adv_to(335);
        chk("rs_wait",  32'(state_a), 32'(ST_WAIT_LOCK));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
